// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between the display pixel fetch
// (highest priority) and NUM_WR round-robin drawing writers. A starvation
// counter forces a writer slot after MAX_WAIT denied cycles.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   disp_req/disp_addr    display read request and word address
//   disp_gnt              display read accepted this cycle (combinational)
//   disp_rdata/rvalid     registered read return, 2+RD_LAT cycles after grant
//   wr_req/addr/data      per-writer request, packed address and data
//   wr_gnt                one-hot write accepted this cycle (combinational)
//   mem_en/we/addr/wdata  registered RAM drive
//   mem_rdata             RAM read data, RD_LAT cycles after mem_en
//   disp_miss             display request lost to a forced writer slot (comb.)
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
   parameter int unsigned ADDR_W   = 19,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     disp_req,
   input  logic [ADDR_W-1:0]        disp_addr,
   output logic                     disp_gnt,
   output logic [DATA_W-1:0]        disp_rdata,
   output logic                     disp_rvalid,
   input  logic [NUM_WR-1:0]        wr_req,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   output logic [NUM_WR-1:0]        wr_gnt,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     disp_miss
);

   localparam int unsigned PTR_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
   logic              disp_rvalid_q, disp_rvalid_d;
   logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;

   logic              force_slot;
   logic              wr_found;
   logic [PTR_W-1:0]  wr_sel;
   logic              grant_disp;
   logic              grant_wr;

   // Grant decision; grants are suppressed while reset is asserted so all
   // outputs read zero during reset.
   always_comb begin
      force_slot = (wait_cnt_q == WAIT_W'(MAX_WAIT)) && (|wr_req);
      wr_found   = 1'b0;
      wr_sel     = '0;
      for (int unsigned o = 0; o < NUM_WR; o++) begin
         if (!wr_found && wr_req[PTR_W'((32'(rr_ptr_q) + o) % NUM_WR)]) begin
            wr_found = 1'b1;
            wr_sel   = PTR_W'((32'(rr_ptr_q) + o) % NUM_WR);
         end
      end
      grant_disp = !reset && disp_req && !force_slot;
      grant_wr   = !reset && !grant_disp && wr_found;
   end

   assign disp_gnt  = grant_disp;
   assign wr_gnt    = grant_wr ? (NUM_WR'(1) << wr_sel) : '0;
   assign disp_miss = !reset && disp_req && force_slot;

   // Next-state for pointer, starvation counter, RAM drive and read return.
   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      wait_cnt_d    = wait_cnt_q;
      mem_en_d      = grant_disp || grant_wr;
      mem_we_d      = grant_wr;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      rd_pipe_d     = rd_pipe_q << 1;
      disp_rvalid_d = rd_pipe_q[RD_LAT-1];
      disp_rdata_d  = disp_rdata_q;

      if (grant_wr) begin
         mem_addr_d  = wr_addr[32'(wr_sel)*ADDR_W +: ADDR_W];
         mem_wdata_d = wr_data[32'(wr_sel)*DATA_W +: DATA_W];
         rr_ptr_d    = (32'(wr_sel) == NUM_WR - 1) ? '0 : PTR_W'(32'(wr_sel) + 1);
      end else if (grant_disp) begin
         mem_addr_d = disp_addr;
      end

      if (grant_wr || (wr_req == '0)) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end

      // Tag enters the pipe when the read is on the RAM port; the last stage
      // lines up with mem_rdata becoming valid.
      rd_pipe_d[0] = mem_en_q && !mem_we_q;
      if (rd_pipe_q[RD_LAT-1]) begin
         disp_rdata_d = mem_rdata;
      end
   end

   // State registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_q      <= '0;
         wait_cnt_q    <= '0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         rd_pipe_q     <= '0;
         disp_rvalid_q <= 1'b0;
         disp_rdata_q  <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_en_q      <= mem_en_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         rd_pipe_q     <= rd_pipe_d;
         disp_rvalid_q <= disp_rvalid_d;
         disp_rdata_q  <= disp_rdata_d;
      end
   end

   assign mem_en      = mem_en_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign disp_rvalid = disp_rvalid_q;
   assign disp_rdata  = disp_rdata_q;

endmodule
